// File: rtl/mac_result_drain_if.sv
// Handshake bundle for mac_result_drain.
// Carries the DSP issue/alignment inputs (issue_valid, issue_last, p_in)
// and the downstream valid/ready result channel (out_*).
// The slave modport is the drain's own view; master is the surrounding logic.
interface mac_result_drain_if #(
  parameter int P_WIDTH   = 16,
  parameter int OUT_WIDTH = 8
);
  logic                 issue_valid;
  logic                 issue_last;
  logic [P_WIDTH-1:0]   p_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;

  modport master (
    output issue_valid, issue_last, p_in, out_ready,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  issue_valid, issue_last, p_in, out_ready,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_result_drain.sv
// mac_result_drain: consumer end of the DSP MAC datapath.
// Aligns issue markers with the DSP output P, accumulates a dot product,
// requantizes (arithmetic shift + saturation) and queues the results in a
// small valid/ready FIFO.
// Optional build macro: MAC_DRAIN_RELU_EN -- when defined, negative results
// are forced to zero after saturation (out_sat is not affected by that clamp).
module mac_result_drain #(
  parameter int P_WIDTH     = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 8,
  parameter int MAC_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_result_drain_if.slave    bus,
  output logic                 busy,
  output logic                 overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = OUT_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ACC_WIDTH'(-(1 << (OUT_WIDTH - 1)));

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                        state_r;
  logic [MAC_LATENCY-1:0]        valid_sr_r;
  logic [MAC_LATENCY-1:0]        last_sr_r;
  logic signed [ACC_WIDTH-1:0]   acc_r;

  logic                          a_valid_s;
  logic                          a_last_s;
  logic signed [ACC_WIDTH-1:0]   p_ext_s;
  logic signed [ACC_WIDTH-1:0]   sum_s;
  logic signed [ACC_WIDTH-1:0]   q_s;
  logic [OUT_WIDTH-1:0]          res_s;
  logic                          sat_s;
  logic                          push_s;

  logic [ENT_W-1:0]              mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_r;
  logic [PTR_W-1:0]              rd_ptr_r;
  logic [CNT_W-1:0]              count_r;
  logic                          full_s;
  logic                          pop_s;
  logic                          wr_ok_s;
  logic                          overflow_r;

  assign a_valid_s = valid_sr_r[MAC_LATENCY-1];
  assign a_last_s  = last_sr_r[MAC_LATENCY-1];
  assign p_ext_s   = $signed({{(ACC_WIDTH - P_WIDTH){bus.p_in[P_WIDTH-1]}}, bus.p_in});
  assign push_s    = a_valid_s & a_last_s;

  // Delay issue markers by the DSP latency so they line up with p_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr_r <= '0;
      last_sr_r  <= '0;
    end else begin
      valid_sr_r[0] <= bus.issue_valid;
      last_sr_r[0]  <= bus.issue_valid & bus.issue_last;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        valid_sr_r[i] <= valid_sr_r[i-1];
        last_sr_r[i]  <= last_sr_r[i-1];
      end
    end
  end

  // Running sum including this cycle's P, then floor shift, clamp and optional ReLU.
  always_comb begin
    sum_s = p_ext_s;
    q_s   = '0;
    res_s = '0;
    sat_s = 1'b0;
    if (state_r == ST_ACCUM) begin
      sum_s = acc_r + p_ext_s;
    end else begin
      sum_s = p_ext_s;
    end
    q_s = sum_s >>> SHIFT;
    if (q_s > Q_MAX) begin
      res_s = OUT_WIDTH'(Q_MAX);
      sat_s = 1'b1;
    end else if (q_s < Q_MIN) begin
      res_s = OUT_WIDTH'(Q_MIN);
      sat_s = 1'b1;
    end else begin
      res_s = q_s[OUT_WIDTH-1:0];
      sat_s = 1'b0;
    end
`ifdef MAC_DRAIN_RELU_EN
    if (res_s[OUT_WIDTH-1]) begin
      res_s = '0;
    end else begin
      res_s = res_s;
    end
`else
    res_s = res_s;
`endif
  end

  // Dot-product FSM: opens a partial sum on the first aligned term, closes it on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      acc_r   <= '0;
    end else if (a_valid_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!a_last_s) begin
            acc_r   <= sum_s;
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (!a_last_s) begin
            acc_r   <= sum_s;
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          acc_r   <= '0;
        end
      endcase
    end
  end

  // Pop is resolved before push, so a full FIFO being drained still accepts a result.
  assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign pop_s   = (count_r != CNT_W'(0)) & bus.out_ready;
  assign wr_ok_s = push_s & (~full_s | pop_s);

  // Result FIFO storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= {sat_s, res_s};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (push_s & full_s & ~pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (count_r != CNT_W'(0));
  assign bus.out_data  = mem_r[rd_ptr_r][OUT_WIDTH-1:0];
  assign bus.out_sat   = mem_r[rd_ptr_r][OUT_WIDTH];
  assign busy          = (state_r == ST_ACCUM) | (|valid_sr_r);
  assign overflow_err  = overflow_r;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain (MAC_LATENCY=3, SHIFT=8, FIFO_DEPTH=4, OUT_WIDTH=8).
// Expected values are hand-computed constants; MAC_DRAIN_RELU_EN changes the
// expectations for negative results.
module tb_mac_result_drain;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic overflow_err;
  int   n_checks = 0;
  int   n_errors = 0;

  mac_result_drain_if #(.P_WIDTH(16), .OUT_WIDTH(8)) bus ();

  mac_result_drain #(
    .P_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(8),
    .SHIFT(8), .MAC_LATENCY(3), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_last  = 1'b0;
    bus.p_in        = 16'h0000;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue n back-to-back terms starting now; p_in follows 3 cycles later.
  task automatic run_dot(input int n, input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic rdy_at_push, input logic chk_lat);
    logic [15:0] v [3];
    v[0] = v0;
    v[1] = v1;
    v[2] = v2;
    for (int c = 0; c < n + 3; c++) begin
      bus.issue_valid = (c < n);
      bus.issue_last  = (c == n - 1);
      bus.p_in        = (c >= 3 && c - 3 < n) ? v[c-3] : 16'h0000;
      if (rdy_at_push && c == n + 2) bus.out_ready = 1'b1;
      if (chk_lat && c == n + 2) check_eq("latency_not_early", {31'd0, bus.out_valid}, 32'd0);
      if (c == 1) check_eq("busy_inflight", {31'd0, busy}, 32'd1);
      tick();
      bus.out_ready = 1'b0;
    end
    bus.issue_valid = 1'b0;
    bus.issue_last  = 1'b0;
    bus.p_in        = 16'h0000;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] data, input logic sat);
    check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, bus.out_data}, {24'd0, data});
    check_eq({tag, "_sat"}, {31'd0, bus.out_sat}, {31'd0, sat});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check_eq("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow_err}, 32'd0);

    // 1: single term, exact latency
    run_dot(1, 16'h0280, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);
    pop_expect("t1", 8'h02, 1'b0);
    check_eq("t1_empty", {31'd0, bus.out_valid}, 32'd0);

    // 2: three-term dot product -> 0x3000 >> 8
    run_dot(3, 16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0);
    pop_expect("t2", 8'h30, 1'b0);
    check_eq("t2_single_result", {31'd0, bus.out_valid}, 32'd0);

    // 3: saturation and negative results
    run_dot(2, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    pop_expect("t3_pos_sat", 8'h7F, 1'b1);
    run_dot(1, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef MAC_DRAIN_RELU_EN
    pop_expect("t3_min", 8'h00, 1'b0);
`else
    pop_expect("t3_min", 8'h80, 1'b0);
`endif
    run_dot(2, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0);
`ifdef MAC_DRAIN_RELU_EN
    pop_expect("t3_neg_sat", 8'h00, 1'b1);
`else
    pop_expect("t3_neg_sat", 8'h80, 1'b1);
`endif

    // 4: fill with out_ready low, fifth result is dropped
    for (int k = 1; k <= 4; k++) begin
      run_dot(1, 16'(k * 256), 16'h0000, 16'h0000, 1'b0, 1'b0);
    end
    check_eq("t4_no_ovf_yet", {31'd0, overflow_err}, 32'd0);
    run_dot(1, 16'h0500, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check_eq("t4_ovf", {31'd0, overflow_err}, 32'd1);
    tick();
    tick();
    check_eq("t4_head_stable", {24'd0, bus.out_data}, 32'h01);
    check_eq("t4_valid_held", {31'd0, bus.out_valid}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pop_expect("t4_drain", 8'(k), 1'b0);
    end
    check_eq("t4_empty", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t4_ovf_sticky", {31'd0, overflow_err}, 32'd1);

    // 5: full FIFO with a pop in the push cycle keeps every result
    do_reset();
    check_eq("t5_ovf_cleared", {31'd0, overflow_err}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      run_dot(1, 16'(k * 256), 16'h0000, 16'h0000, 1'b0, 1'b0);
    end
    run_dot(1, 16'h0500, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check_eq("t5_no_ovf", {31'd0, overflow_err}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      pop_expect("t5_drain", 8'(k), 1'b0);
    end
    check_eq("t5_empty", {31'd0, bus.out_valid}, 32'd0);

    // 6: reset mid dot product discards in-flight terms
    bus.issue_valid = 1'b1;
    bus.issue_last  = 1'b0;
    tick();
    tick();
    bus.issue_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    bus.p_in = 16'h7FFF;
    for (int k = 0; k < 4; k++) tick();
    bus.p_in = 16'h0000;
    check_eq("t6_nothing_pushed", {31'd0, bus.out_valid}, 32'd0);
    run_dot(1, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    pop_expect("t6", 8'h01, 1'b0);
    check_eq("t6_busy_drained", {31'd0, busy}, 32'd0);
    check_eq("t6_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
